// File: rtl/spm_bank_scheduler_pkg.sv
// Shared SPM read-path sizing and bank index type for the bank conflict scheduler.
package spm_bank_scheduler_pkg;

  localparam int SM_PROCESSING_ELEMENTS = 16;
  localparam int SM_MEMORY_BANKS        = 16;
  localparam int SM_BANK_ADDR_W         = $clog2(SM_MEMORY_BANKS);

  typedef logic [SM_BANK_ADDR_W-1:0] sm_bank_address_t;

  // Width of a pass counter that must count up to n passes.
  function automatic int pass_id_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/spm_conflict_grant.sv
// Combinational bank-conflict arbiter: lowest pending lane wins each bank.
// Also flags whether this grant drains every pending lane.
module spm_conflict_grant
  import spm_bank_scheduler_pkg::*;
#(
  parameter int N_LANES = SM_PROCESSING_ELEMENTS,
  parameter int BANK_W  = SM_BANK_ADDR_W
) (
  input  logic [N_LANES-1:0]        pending,
  input  logic [N_LANES*BANK_W-1:0] bank_indexes,
  output logic [N_LANES-1:0]        grant,
  output logic                      last
);

  // Grant lane i unless a lower pending lane targets the same bank.
  always_comb begin
    grant = '0;
    for (int i = 0; i < N_LANES; i++) begin : g_lane
      logic hit;
      hit = 1'b0;
      for (int j = 0; j < i; j++) begin
        hit = hit | (pending[j] &
              (bank_indexes[j*BANK_W +: BANK_W] == bank_indexes[i*BANK_W +: BANK_W]));
      end
      grant[i] = pending[i] & ~hit;
    end
    last = ((pending & ~grant) == '0);
  end

endmodule

// File: rtl/spm_bank_scheduler.sv
// SPM read-path conflict scheduler: splits a lane request into conflict-free
// bank passes, issued one per cycle under valid/ready backpressure.
module spm_bank_scheduler
  import spm_bank_scheduler_pkg::*;
#(
  parameter int N_LANES = SM_PROCESSING_ELEMENTS,
  parameter int N_BANKS = SM_MEMORY_BANKS,
  localparam int BANK_W = $clog2(N_BANKS),
  localparam int ID_W   = pass_id_width(N_LANES)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic [N_LANES-1:0]        req_mask,
  input  logic [N_LANES*BANK_W-1:0] req_bank_indexes,
  output logic                      pass_valid,
  input  logic                      pass_ready,
  output logic [N_LANES-1:0]        pass_mask,
  output logic [N_LANES*BANK_W-1:0] pass_bank_indexes,
  output logic                      pass_last,
  output logic [ID_W-1:0]           pass_id
);

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } state_t;

  state_t                    state_q, state_d;
  logic [N_LANES-1:0]        pending_q, pending_d;
  logic [N_LANES*BANK_W-1:0] bank_q, bank_d;
  logic [ID_W-1:0]           pass_id_q, pass_id_d;
  logic [N_LANES-1:0]        grant;
  logic                      last;

  spm_conflict_grant #(
    .N_LANES (N_LANES),
    .BANK_W  (BANK_W)
  ) u_grant (
    .pending      (pending_q),
    .bank_indexes (bank_q),
    .grant        (grant),
    .last         (last)
  );

  // Next-state and handshake decode; a request accepted on the last pass
  // overrides the return to IDLE so back-to-back requests need no bubble.
  always_comb begin
    state_d    = state_q;
    pending_d  = pending_q;
    bank_d     = bank_q;
    pass_id_d  = pass_id_q;
    req_ready  = 1'b0;
    pass_valid = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
      end
      ISSUE: begin
        pass_valid = 1'b1;
        req_ready  = pass_ready & last;
        if (pass_ready) begin
          pending_d = pending_q & ~grant;
          if (last) begin
            state_d   = IDLE;
            pass_id_d = '0;
          end else begin
            pass_id_d = pass_id_q + ID_W'(1);
          end
        end else begin
          pending_d = pending_q;
        end
      end
      default: begin
        state_d   = IDLE;
        pending_d = '0;
      end
    endcase
    if (req_valid && req_ready) begin
      state_d   = ISSUE;
      pending_d = req_mask;
      bank_d    = req_bank_indexes;
      pass_id_d = '0;
    end else begin
      bank_d = bank_q;
    end
  end

  // Scheduler state registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      pending_q <= '0;
      bank_q    <= '0;
      pass_id_q <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      bank_q    <= bank_d;
      pass_id_q <= pass_id_d;
    end
  end

  assign pass_mask         = grant;
  assign pass_last         = last;
  assign pass_id           = pass_id_q;
  assign pass_bank_indexes = bank_q;

endmodule

// File: tb/tb_spm_bank_scheduler.sv
// Scoreboard bench for spm_bank_scheduler: directed requests push expected
// passes; a negedge monitor compares every presented pass against the queue head.
module tb_spm_bank_scheduler;

  typedef struct {
    logic [15:0] mask;
    logic        last;
    logic [4:0]  id;
    logic [63:0] banks;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [15:0] req_mask;
  logic [63:0] req_bank_indexes;
  logic        pass_valid;
  logic        pass_ready;
  logic [15:0] pass_mask;
  logic [63:0] pass_bank_indexes;
  logic        pass_last;
  logic [4:0]  pass_id;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  localparam logic [63:0] BANKS_ID   = 64'hFEDC_BA98_7654_3210;
  localparam logic [63:0] BANKS_B3   = 64'h3333_3333_3333_3333;
  localparam logic [63:0] BANKS_PART = 64'h0000_0000_0000_5255;

  spm_bank_scheduler dut (
    .clk               (clk),
    .reset             (reset),
    .req_valid         (req_valid),
    .req_ready         (req_ready),
    .req_mask          (req_mask),
    .req_bank_indexes  (req_bank_indexes),
    .pass_valid        (pass_valid),
    .pass_ready        (pass_ready),
    .pass_mask         (pass_mask),
    .pass_bank_indexes (pass_bank_indexes),
    .pass_last         (pass_last),
    .pass_id           (pass_id)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [15:0] m, input logic l, input logic [4:0] id,
                      input logic [63:0] b);
    exp_t e;
    e.mask  = m;
    e.last  = l;
    e.id    = id;
    e.banks = b;
    sb.push_back(e);
  endtask

  task automatic do_req(input logic [15:0] m, input logic [63:0] b);
    int n;
    n = 0;
    req_valid        = 1'b1;
    req_mask         = m;
    req_bank_indexes = b;
    while (!req_ready && n < 50) begin
      step();
      n++;
    end
    if (!req_ready) chk("req_accept_timeout", {63'd0, req_ready}, 64'd1);
    step();
    req_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      step();
      n++;
    end
    chk("drain_timeout", 64'(sb.size()), 64'd0);
  endtask

  // Monitor: every presented pass must match the queue head; pop on handshake.
  always @(negedge clk) begin
    if (reset && pass_valid) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pass: got mask %0h expected no pass", pass_mask);
      end else begin
        chk("pass_mask", 64'(pass_mask), 64'(sb[0].mask));
        chk("pass_last", 64'(pass_last), 64'(sb[0].last));
        chk("pass_id", 64'(pass_id), 64'(sb[0].id));
        chk("pass_bank_indexes", pass_bank_indexes, sb[0].banks);
        if (pass_ready) void'(sb.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset            = 1'b0;
    req_valid        = 1'b0;
    req_mask         = '0;
    req_bank_indexes = '0;
    pass_ready       = 1'b1;
    repeat (2) step();
    chk("rst_req_ready", 64'(req_ready), 64'd1);
    chk("rst_pass_valid", 64'(pass_valid), 64'd0);
    chk("rst_pass_mask", 64'(pass_mask), 64'd0);
    chk("rst_pass_last", 64'(pass_last), 64'd1);
    chk("rst_pass_id", 64'(pass_id), 64'd0);
    chk("rst_pass_banks", pass_bank_indexes, 64'd0);
    reset = 1'b1;
    step();

    // No conflicts: single pass one cycle after acceptance.
    push(16'hFFFF, 1'b1, 5'd0, BANKS_ID);
    do_req(16'hFFFF, BANKS_ID);
    chk("first_pass_latency", 64'(pass_valid), 64'd1);
    drain();

    // Full conflict: one lane per pass in ascending order.
    for (int k = 0; k < 16; k++) push(16'(1 << k), (k == 15), 5'(k), BANKS_B3);
    do_req(16'hFFFF, BANKS_B3);
    drain();

    // Partial: lanes {0,1,3} on bank 5, lane 2 on bank 2.
    push(16'h0005, 1'b0, 5'd0, BANKS_PART);
    push(16'h0002, 1'b0, 5'd1, BANKS_PART);
    push(16'h0008, 1'b1, 5'd2, BANKS_PART);
    do_req(16'h000F, BANKS_PART);
    drain();

    // Same request with the first pass stalled for four cycles.
    pass_ready = 1'b0;
    push(16'h0005, 1'b0, 5'd0, BANKS_PART);
    push(16'h0002, 1'b0, 5'd1, BANKS_PART);
    push(16'h0008, 1'b1, 5'd2, BANKS_PART);
    do_req(16'h000F, BANKS_PART);
    repeat (4) step();
    chk("stall_no_consume", 64'(sb.size()), 64'd3);
    pass_ready = 1'b1;
    drain();

    // Zero-mask request followed back-to-back by the no-conflict request.
    push(16'h0000, 1'b1, 5'd0, 64'd0);
    do_req(16'h0000, 64'd0);
    chk("req_ready_last_pass", 64'(req_ready), 64'd1);
    push(16'hFFFF, 1'b1, 5'd0, BANKS_ID);
    do_req(16'hFFFF, BANKS_ID);
    chk("back_to_back_valid", 64'(pass_valid), 64'd1);
    drain();

    // Reset during pass 2 of the full-conflict request.
    for (int k = 0; k < 16; k++) push(16'(1 << k), (k == 15), 5'(k), BANKS_B3);
    do_req(16'hFFFF, BANKS_B3);
    step();
    chk("pre_reset_pass_id", 64'(pass_id), 64'd1);
    reset = 1'b0;
    #1;
    chk("mid_rst_pass_valid", 64'(pass_valid), 64'd0);
    chk("mid_rst_req_ready", 64'(req_ready), 64'd1);
    chk("mid_rst_pass_mask", 64'(pass_mask), 64'd0);
    chk("mid_rst_pass_id", 64'(pass_id), 64'd0);
    sb.delete();
    step();
    reset = 1'b1;
    step();
    chk("post_rst_idle", 64'(pass_valid), 64'd0);
    push(16'h0005, 1'b0, 5'd0, BANKS_PART);
    push(16'h0002, 1'b0, 5'd1, BANKS_PART);
    push(16'h0008, 1'b1, 5'd2, BANKS_PART);
    do_req(16'h000F, BANKS_PART);
    chk("post_rst_first_id", 64'(pass_id), 64'd0);
    drain();

    step();
    chk("final_idle", 64'(pass_valid), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
